// File: rtl/fsic_clock_phase_det.sv
// Checks the fsic_clock divided clock against an expected DIV ratio and 50% duty,
// reporting lock, phase within the period, edge strobes and a saturating error count.
module fsic_clock_phase_det #(
  parameter int DIV      = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic       ioclk,
  input  logic       resetb,
  input  logic       en,
  input  logic       clk_div_in,
  input  logic       err_clr,
  output logic       locked,
  output logic [3:0] phase,
  output logic       rise_stb,
  output logic       err_stb,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] PER_LAST  = 4'(DIV - 1);
  localparam logic [3:0] HALF_LAST = 4'(DIV / 2 - 1);
  localparam logic [3:0] GOOD_LAST = 4'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    TRAIN  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    if (v == 4'd15) begin
      return 4'd15;
    end else begin
      return v + 4'd1;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return 8'd255;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t     state_q, state_d;
  logic       d1_q, d1_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d;
  logic [3:0] phase_q, phase_d;
  logic       rise_stb_q, rise_stb_d;
  logic       err_stb_q, err_stb_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic rise_s, fall_s, checking_s, err_s, good_s;

  // Edge detection, violation classification and next-state computation.
  always_comb begin
    rise_s     = clk_div_in & ~d1_q;
    fall_s     = ~clk_div_in & d1_q;
    checking_s = (state_q == TRAIN) || (state_q == LOCKED);
    good_s     = rise_s && (pcnt_q == PER_LAST);
    // Early rise, missing rise at the period boundary, or a fall off the half period.
    err_s      = en && checking_s &&
                 ((rise_s && (pcnt_q < PER_LAST)) ||
                  (!rise_s && (pcnt_q == PER_LAST)) ||
                  (fall_s && (pcnt_q != HALF_LAST)));

    d1_d       = clk_div_in;
    state_d    = state_q;
    good_cnt_d = good_cnt_q;

    if (!en) begin
      state_d    = IDLE;
      good_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SEEK;
          good_cnt_d = 4'd0;
        end
        SEEK: begin
          if (rise_s) begin
            state_d    = TRAIN;
            good_cnt_d = 4'd0;
          end else begin
            state_d = SEEK;
          end
        end
        TRAIN: begin
          if (err_s) begin
            state_d    = SEEK;
            good_cnt_d = 4'd0;
          end else if (good_s) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            state_d = TRAIN;
          end
        end
        LOCKED: begin
          if (err_s) begin
            state_d    = SEEK;
            good_cnt_d = 4'd0;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d    = IDLE;
          good_cnt_d = 4'd0;
        end
      endcase
    end

    if (!en || (state_q == IDLE)) begin
      pcnt_d = 4'd0;
    end else if (rise_s) begin
      pcnt_d = 4'd0;
    end else begin
      pcnt_d = sat_inc4(pcnt_q);
    end

    // Outputs are registered from next-state values so they align with the state.
    locked_d   = (state_d == LOCKED);
    if (locked_d) begin
      phase_d = pcnt_d;
    end else begin
      phase_d = 4'd0;
    end
    rise_stb_d = rise_s && en && (state_q != IDLE);
    err_stb_d  = err_s;

    if (err_clr) begin
      err_cnt_d = err_s ? 8'd1 : 8'd0;
    end else if (err_s) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ioclk) begin
    if (!resetb) begin
      state_q    <= IDLE;
      d1_q       <= 1'b0;
      pcnt_q     <= 4'd0;
      good_cnt_q <= 4'd0;
      locked_q   <= 1'b0;
      phase_q    <= 4'd0;
      rise_stb_q <= 1'b0;
      err_stb_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      d1_q       <= d1_d;
      pcnt_q     <= pcnt_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      phase_q    <= phase_d;
      rise_stb_q <= rise_stb_d;
      err_stb_q  <= err_stb_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked   = locked_q;
  assign phase    = phase_q;
  assign rise_stb = rise_stb_q;
  assign err_stb  = err_stb_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fsic_clock_phase_det.sv
// Drives directed and random divided-clock waveforms and compares every output,
// every cycle, against an event-timestamp reference model.
module tb_fsic_clock_phase_det;

  localparam int DIV      = 4;
  localparam int LOCK_CNT = 4;
  localparam int M_IDLE   = 0;
  localparam int M_SEEK   = 1;
  localparam int M_TRAIN  = 2;
  localparam int M_LOCKED = 3;

  logic       ioclk = 1'b0;
  logic       resetb, en, clk_div_in, err_clr;
  logic       locked;
  logic [3:0] phase;
  logic       rise_stb, err_stb;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: time of the last rise (or of the last forced restart), mode,
  // number of good periods seen in training, error count.
  int m_t = 0, m_last_rise = 0, m_prev_in = 0, m_mode = M_IDLE, m_good = 0, m_cnt = 0;
  int e_locked = 0, e_phase = 0, e_rise = 0, e_err = 0;

  fsic_clock_phase_det #(.DIV(DIV), .LOCK_CNT(LOCK_CNT)) dut (
    .ioclk      (ioclk),
    .resetb     (resetb),
    .en         (en),
    .clk_div_in (clk_div_in),
    .err_clr    (err_clr),
    .locked     (locked),
    .phase      (phase),
    .rise_stb   (rise_stb),
    .err_stb    (err_stb),
    .err_cnt    (err_cnt)
  );

  always #5 ioclk = ~ioclk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input logic rb, input logic e, input logic din, input logic clr);
    int age;
    bit rise, fall, bad, good_per, was_idle;
    m_t++;
    if (!rb) begin
      m_mode = M_IDLE; m_good = 0; m_cnt = 0; m_prev_in = 0; m_last_rise = m_t;
      e_locked = 0; e_phase = 0; e_rise = 0; e_err = 0;
    end else begin
      age       = m_t - m_last_rise;
      rise      = (din == 1'b1) && (m_prev_in == 0);
      fall      = (din == 1'b0) && (m_prev_in == 1);
      m_prev_in = (din == 1'b1) ? 1 : 0;
      good_per  = rise && (age == DIV);
      bad       = e && (m_mode >= M_TRAIN) &&
                  ((rise && age < DIV) || (!rise && age == DIV) || (fall && age != DIV / 2));
      e_rise    = (rise && e && m_mode != M_IDLE) ? 1 : 0;
      e_err     = bad ? 1 : 0;
      was_idle  = (m_mode == M_IDLE);
      if (!e) begin
        m_mode = M_IDLE; m_good = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_SEEK;
      end else if (bad) begin
        m_mode = M_SEEK; m_good = 0;
      end else if (m_mode == M_SEEK && rise) begin
        m_mode = M_TRAIN; m_good = 0;
      end else if (m_mode == M_TRAIN && good_per) begin
        m_good++;
        if (m_good == LOCK_CNT) m_mode = M_LOCKED;
      end
      if (!e || was_idle || rise) m_last_rise = m_t;
      if (clr) m_cnt = bad ? 1 : 0;
      else if (bad && m_cnt < 255) m_cnt++;
      e_locked = (m_mode == M_LOCKED) ? 1 : 0;
      e_phase  = e_locked ? imin(m_t - m_last_rise, 15) : 0;
    end
  endtask

  task automatic step(input logic din, input logic clr, input logic rb);
    clk_div_in = din;
    err_clr    = clr;
    resetb     = rb;
    @(posedge ioclk);
    model_edge(rb, en, din, clr);
    #1;
    check("locked",   int'(locked),   e_locked);
    check("phase",    int'(phase),    e_phase);
    check("rise_stb", int'(rise_stb), e_rise);
    check("err_stb",  int'(err_stb),  e_err);
    check("err_cnt",  int'(err_cnt),  m_cnt);
  endtask

  task automatic run_period(input int hi, input int lo, input int clr_at, input int rst_at);
    for (int i = 0; i < hi + lo; i++) begin
      step(i < hi, i == clr_at, i != rst_at);
    end
  endtask

  initial begin
    int hi, lo, clr_at, rst_at;
    resetb = 1'b0; en = 1'b0; clk_div_in = 1'b0; err_clr = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // Clean divide-by-4 locks on the fifth rise.
    en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    repeat (7) run_period(2, 2, -1, -1);
    check("clean_lock", int'(locked), 1);

    // One period stretched to five cycles: single late error, then relock.
    run_period(2, 3, -1, -1);
    check("stretch_unlock", int'(locked), 0);
    check("stretch_cnt", int'(err_cnt), 1);
    repeat (5) run_period(2, 2, -1, -1);
    check("stretch_relock", int'(locked), 1);

    // 75% duty: one error per period, count saturates.
    repeat (300) run_period(3, 1, -1, -1);
    check("duty_sat", int'(err_cnt), 255);
    check("duty_nolock", int'(locked), 0);

    // err_clr coincident with an error, then alone.
    repeat (6) run_period(2, 2, -1, -1);
    run_period(3, 1, 3, -1);
    check("clr_with_err", int'(err_cnt), 1);
    run_period(2, 2, 1, -1);
    check("clr_alone", int'(err_cnt), 0);

    // Dropping en while locked.
    repeat (6) run_period(2, 2, -1, -1);
    en = 1'b0;
    run_period(2, 2, -1, -1);
    check("en_off_locked", int'(locked), 0);
    check("en_off_phase", int'(phase), 0);
    en = 1'b1;
    repeat (7) run_period(2, 2, -1, -1);
    check("en_on_relock", int'(locked), 1);

    // Reset while locked with seven errors counted.
    repeat (7) run_period(3, 1, -1, -1);
    repeat (6) run_period(2, 2, -1, -1);
    check("pre_rst_cnt", int'(err_cnt), 7);
    check("pre_rst_lock", int'(locked), 1);
    step(1'b1, 1'b1, 1'b0);
    check("mid_rst_cnt", int'(err_cnt), 0);
    check("mid_rst_lock", int'(locked), 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (6) run_period(2, 2, -1, -1);
    check("post_rst_relock", int'(locked), 1);

    // Random waveforms, enables, clears and resets.
    repeat (400) begin
      if ($urandom_range(0, 9) < 7) begin
        hi = 2; lo = 2;
      end else begin
        hi = $urandom_range(1, 4); lo = $urandom_range(1, 4);
      end
      en     = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
      clr_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      rst_at = ($urandom_range(0, 99) == 0) ? $urandom_range(0, hi + lo - 1) : -1;
      run_period(hi, lo, clr_at, rst_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fsic_clock_phase_det.md
FSIC_CLOCK_PHASE_DET -- requirements
Module: fsic_clock_phase_det

Interface
REQ-001 SHALL have parameter DIV, default 4: expected divided-clock period in ioclk cycles; even, 2..16.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive good periods required for lock; 1..15.
REQ-003 SHALL have port ioclk  input  1  single clock (the undivided I/O clock); all logic on rising edge.
REQ-004 SHALL have port resetb  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port en  input  1  detector enable; 0 forces IDLE.
REQ-006 SHALL have port clk_div_in  input  1  divided clock from fsic_clock divider, synchronous to ioclk, sampled as data.
REQ-007 SHALL have port err_clr  input  1  one-cycle pulse, clears err_cnt.
REQ-008 SHALL have port locked  output  1  divided clock verified at DIV ratio and 50% duty.
REQ-009 SHALL have port phase  output  4  ioclk cycles since last divided-clock rise, valid when locked.
REQ-010 SHALL have port rise_stb  output  1  one-cycle pulse per detected rising edge of clk_div_in.
REQ-011 SHALL have port err_stb  output  1  one-cycle pulse per period/duty violation.
REQ-012 SHALL have port err_cnt  output  8  saturating violation count.

Function
REQ-013 SHALL register clk_div_in into d1; rise = clk_div_in & ~d1; fall = ~clk_div_in & d1 (combinational, cycle E).
REQ-014 SHALL keep period counter pcnt (4 bit): rise -> 0 next cycle; else +1, saturating at 15.
REQ-015 SHALL implement states IDLE, SEEK, TRAIN, LOCKED; en=0 -> IDLE from any state, highest priority.
REQ-016 IDLE: en=1 -> SEEK; pcnt, good_cnt held at 0.
REQ-017 SEEK: first rise -> TRAIN, good_cnt=0; no errors flagged in SEEK.
REQ-018 Good period: rise with pcnt==DIV-1 (edge DIV cycles after previous rise).
REQ-019 Errors (TRAIN/LOCKED only): rise with pcnt<DIV-1 (early); pcnt==DIV-1 and no rise (late/missing); fall with pcnt!=DIV/2-1 (duty).
REQ-020 TRAIN: good period with good_cnt==LOCK_CNT-1 -> LOCKED; other good period -> good_cnt+1.
REQ-021 Any error in TRAIN or LOCKED -> SEEK, good_cnt=0; an early rise in the same cycle does not re-enter TRAIN directly.
REQ-022 locked=1 exactly while state==LOCKED, registered (first high cycle after the locking edge).
REQ-023 phase = pcnt when LOCKED, else 0; phase rises 0,1,..,DIV-1 and wraps to 0 on each rise.
REQ-024 rise_stb registered, high the cycle after rise, in SEEK/TRAIN/LOCKED; never in IDLE.
REQ-025 err_stb registered, high the cycle after an error; multiple error conditions in one cycle give one pulse, one count.
REQ-026 err_cnt +1 per err_stb, saturating at 255; err_clr clears; err_clr with simultaneous error -> 1.
REQ-027 err_cnt held (not cleared) when en=0.

Reset
REQ-028 resetb=0 sampled at ioclk rising edge -> next cycle: state IDLE, d1=0, pcnt=0, good_cnt=0, locked=0, phase=0, rise_stb=0, err_stb=0, err_cnt=0.
REQ-029 Reset mid-operation (any state) SHALL take effect at that edge regardless of en, err_clr, clk_div_in.
REQ-030 No asynchronous path from resetb to any flop.

Verification
REQ-031 DIV=4, LOCK_CNT=4, clean div-by-4 (2 high/2 low), en=1 -> first rise to TRAIN; locked=1 one cycle after 5th rise; phase cycles 0,1,2,3.
REQ-032 Locked, one period stretched to 5 cycles -> err_stb one pulse at pcnt==3+1 cycle, locked=0, err_cnt=1; relock after 5 further clean rises.
REQ-033 Locked, high phase 3 cycles / low 1 (period 4) -> duty error each period, never relocks; err_cnt increments per period, saturates at 255.
REQ-034 err_clr asserted same cycle as error -> err_cnt=1; err_clr alone -> err_cnt=0.
REQ-035 en dropped while locked -> next cycle IDLE, locked=0, phase=0, rise_stb silent, err_cnt unchanged; en=1 re-enters SEEK.
REQ-036 resetb=0 for one cycle while locked with err_cnt=7 -> all outputs 0 next cycle; clean clock relocks after LOCK_CNT+1 rises.
